count_capture_fifo: RTL and testbench
=====================================

COUNT_CAPTURE_FIFO -- requirements
Module: count_capture_fifo

Interface
- REQ-001: Block SHALL use one clock `clk`; reset `reset` is synchronous and active-high.
- REQ-002: Parameter `DEPTH`, default 8, number of 4-bit entries; legal values are powers of two, 2..16.
- REQ-003: `clk`  in  1  rising-edge clock for all state.
- REQ-004: `reset`  in  1  synchronous active-high reset.
- REQ-005: `count_i`  in  4  sample from the upstream counter's `count_o`.
- REQ-006: `count_vld_i`  in  1  `count_i` is a valid sample this cycle.
- REQ-007: `pop_i`  in  1  consumer removes the head entry this cycle.
- REQ-008: `data_o`  out  4  head entry (first-word fall-through); 4'h0 when empty.
- REQ-009: `data_vld_o`  out  1  FIFO non-empty; `data_o` is valid.
- REQ-010: `level_o`  out  5  current occupancy, 0..DEPTH.
- REQ-011: `full_o`  out  1  level == DEPTH.
- REQ-012: `empty_o`  out  1  level == 0.
- REQ-013: `ovf_o`  out  1  sticky flag: a push was dropped.
- REQ-014: `ovf_clr_i`  in  1  clears `ovf_o`.

Function
- REQ-015: Storage SHALL be a circular buffer with read and write pointers of log2(DEPTH) bits; pointers wrap from DEPTH-1 to 0.
- REQ-016: Push request = `count_vld_i` AND push-filter pass (see REQ-030/031).
- REQ-017: A push request SHALL write `count_i` at the write pointer and advance it, unless the FIFO is full and `pop_i` is 0.
- REQ-018: A push request while full with `pop_i`=0 SHALL be dropped. `ovf_o` SHALL be 1 from the next cycle.
- REQ-019: `pop_i`=1 while non-empty SHALL advance the read pointer. `pop_i` while empty SHALL be ignored, with no state change.
- REQ-020: A simultaneous push and pop SHALL both take effect, including when full or empty. Level is unchanged, except empty+push+pop, where the pop is ignored and level becomes 1.
- REQ-021: Latency: a pushed value SHALL appear on `data_o` with `data_vld_o`=1 in the cycle after the push edge, when the FIFO was empty.
- REQ-022: `level_o`, `full_o`, `empty_o`, `data_vld_o` SHALL be registered or derived only from registered state. There is no combinational path from inputs.
- REQ-023: `ovf_o` SHALL stay set until `ovf_clr_i`=1. If a drop and `ovf_clr_i` occur in the same cycle, set wins.
- REQ-024: Order SHALL be strictly preserved. No entry is duplicated or lost except drops per REQ-018.

Reset
- REQ-025: On `reset`=1 at a rising edge, pointers, level and `ovf_o` SHALL clear to 0.
- REQ-026: After reset: `empty_o`=1, `full_o`=0, `data_vld_o`=0, `data_o`=4'h0, `level_o`=0.
- REQ-027: Reset SHALL override push, pop and `ovf_clr_i` in the same cycle. In-flight entries are discarded.
- REQ-028: The filter's last-sample register SHALL clear, and its first-sample flag SHALL set, on reset.
- REQ-029: Storage array contents need not be reset.

Configuration
- REQ-030: With macro `CCF_CHANGE_FILTER_EN` defined, a valid sample SHALL pass the filter only when it is the first valid sample since reset or when `count_i` differs from the last valid sample. The last-sample register updates on every `count_vld_i`, including dropped samples.
- REQ-031: Without `CCF_CHANGE_FILTER_EN`, every `count_vld_i` sample SHALL pass, and no last-sample register SHALL exist.

Verification
- REQ-032: Reset then push 3,4,5 on consecutive cycles, no pop -> `level_o`=3; `data_o`=3; pops yield 3,4,5; then `empty_o`=1 and `data_o`=0.
- REQ-033: Push 0..7 (DEPTH=8) then push 9 with `pop_i`=0 -> `full_o`=1, 9 dropped, `ovf_o`=1 next cycle; drain yields 0..7; `ovf_clr_i` pulse -> `ovf_o`=0.
- REQ-034: FIFO full; push 12 with `pop_i`=1 the same cycle -> level stays 8, head advances, 12 appears last on drain, `ovf_o`=0.
- REQ-035: Empty FIFO; push 6 with `pop_i`=1 the same cycle -> `level_o`=1, `data_o`=6 next cycle; pop on empty -> no change.
- REQ-036: With `CCF_CHANGE_FILTER_EN`: samples 2,2,2,3,3,2 -> FIFO holds 2,3,2. Without the macro -> it holds all six.
- REQ-037: Reset asserted with level 5 plus a simultaneous push/pop -> next cycle `level_o`=0, `empty_o`=1, `ovf_o`=0. A later first sample 2 is pushed even if equal to the pre-reset last sample.

Source files
------------

// File: rtl/count_capture_fifo_if.sv
// rtl/count_capture_fifo_if.sv - capture-side and consumer-side signal bundle for count_capture_fifo
interface count_capture_fifo_if;
  logic [3:0] count_i;
  logic       count_vld_i;
  logic       pop_i;
  logic       ovf_clr_i;
  logic [3:0] data_o;
  logic       data_vld_o;
  logic [4:0] level_o;
  logic       full_o;
  logic       empty_o;
  logic       ovf_o;

  modport master (
    output count_i, count_vld_i, pop_i, ovf_clr_i,
    input  data_o, data_vld_o, level_o, full_o, empty_o, ovf_o
  );

  modport slave (
    input  count_i, count_vld_i, pop_i, ovf_clr_i,
    output data_o, data_vld_o, level_o, full_o, empty_o, ovf_o
  );
endinterface

// File: rtl/count_capture_fifo.sv
// rtl/count_capture_fifo.sv - first-word fall-through FIFO capturing 4-bit counter samples
// Optional change-only push filter enabled by defining CCF_CHANGE_FILTER_EN.
module count_capture_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  count_capture_fifo_if.slave  bus
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [4:0]      LVL_FULL = 5'(DEPTH);

  logic [3:0]    mem_q [DEPTH];
  logic [3:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    level_q, level_d;
  logic          ovf_q, ovf_d;

  logic full;
  logic empty;
  logic filt_pass;
  logic push_req;
  logic push_ok;
  logic pop_ok;
  logic drop;

`ifdef CCF_CHANGE_FILTER_EN
  logic [3:0] last_q, last_d;
  logic       first_q, first_d;

  // The last-sample register tracks every valid sample, even ones later dropped as overflow.
  always_comb begin
    last_d    = last_q;
    first_d   = first_q;
    filt_pass = first_q || (bus.count_i != last_q);
    if (bus.count_vld_i) begin
      last_d  = bus.count_i;
      first_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q  <= 4'h0;
      first_q <= 1'b1;
    end else begin
      last_q  <= last_d;
      first_q <= first_d;
    end
  end
`else
  assign filt_pass = 1'b1;
`endif

  always_comb begin
    full  = (level_q == LVL_FULL);
    empty = (level_q == 5'd0);
  end

  // When full, a same-cycle pop frees the slot the write pointer now aliases.
  always_comb begin
    push_req = bus.count_vld_i & filt_pass;
    pop_ok   = bus.pop_i & ~empty;
    push_ok  = push_req & (~full | bus.pop_i);
    drop     = push_req & full & ~bus.pop_i;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = bus.count_i;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    level_d = level_q + {4'b0000, push_ok} - {4'b0000, pop_ok};
    ovf_d   = drop | (ovf_q & ~bus.ovf_clr_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= 5'd0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.data_o     = empty ? 4'h0 : mem_q[rd_ptr_q];
  assign bus.data_vld_o = ~empty;
  assign bus.level_o    = level_q;
  assign bus.full_o     = full;
  assign bus.empty_o    = empty;
  assign bus.ovf_o      = ovf_q;

endmodule

// File: tb/tb_count_capture_fifo.sv
// tb/tb_count_capture_fifo.sv - self-checking bench for count_capture_fifo (queue model plus directed literals)
module tb_count_capture_fifo;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  count_capture_fifo_if bus ();

  count_capture_fifo #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit model_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue, updated from the same sampled inputs at each rising edge.
  int         mq[$];
  bit         m_ovf;
  bit         m_first;
  logic [3:0] m_last;

  always @(posedge clk) begin : model
    bit pass;
    bit was_full;
    bit was_empty;
    if (reset) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_first = 1'b1;
      m_last  = 4'h0;
    end else begin
      pass = 1'b1;
`ifdef CCF_CHANGE_FILTER_EN
      pass = m_first || (bus.count_i != m_last);
      if (bus.count_vld_i) begin
        m_first = 1'b0;
        m_last  = bus.count_i;
      end
`endif
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      if (bus.pop_i && !was_empty) void'(mq.pop_front());
      if (bus.count_vld_i && pass) begin
        if (was_full && !bus.pop_i) m_ovf = 1'b1;
        else mq.push_back(int'(bus.count_i));
      end
      if (!(bus.count_vld_i && pass && was_full && !bus.pop_i) && bus.ovf_clr_i) m_ovf = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (model_en) begin
      chk("m_level", bus.level_o, mq.size());
      chk("m_empty", bus.empty_o, mq.size() == 0);
      chk("m_full",  bus.full_o,  mq.size() == DEPTH);
      chk("m_vld",   bus.data_vld_o, mq.size() != 0);
      chk("m_data",  bus.data_o, (mq.size() == 0) ? 0 : mq[0]);
      chk("m_ovf",   bus.ovf_o, m_ovf);
    end
  end

  task automatic cyc(input logic vld, input logic [3:0] d, input logic pop,
                     input logic clr = 1'b0, input logic rst = 1'b0);
    bus.count_vld_i = vld;
    bus.count_i     = d;
    bus.pop_i       = pop;
    bus.ovf_clr_i   = clr;
    reset           = rst;
    @(posedge clk);
    #1;
    bus.count_vld_i = 1'b0;
    bus.pop_i       = 1'b0;
    bus.ovf_clr_i   = 1'b0;
    reset           = 1'b0;
  endtask

  task automatic expect_pop(input string name, input logic [3:0] v);
    chk(name, bus.data_o, v);
    cyc(1'b0, 4'h0, 1'b1);
  endtask

  int exp_f[$];

  initial begin
    bus.count_i     = 4'h0;
    bus.count_vld_i = 1'b0;
    bus.pop_i       = 1'b0;
    bus.ovf_clr_i   = 1'b0;
    reset           = 1'b1;

    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    model_en = 1'b1;
    chk("rst_empty", bus.empty_o, 1);
    chk("rst_full",  bus.full_o, 0);
    chk("rst_vld",   bus.data_vld_o, 0);
    chk("rst_data",  bus.data_o, 0);
    chk("rst_level", bus.level_o, 0);
    chk("rst_ovf",   bus.ovf_o, 0);

    // push 3,4,5 then drain
    cyc(1'b1, 4'd3, 1'b0);
    chk("lat_vld", bus.data_vld_o, 1);
    chk("lat_data", bus.data_o, 3);
    cyc(1'b1, 4'd4, 1'b0);
    cyc(1'b1, 4'd5, 1'b0);
    chk("p3_level", bus.level_o, 3);
    chk("p3_data", bus.data_o, 3);
    expect_pop("p3_pop0", 4'd3);
    expect_pop("p3_pop1", 4'd4);
    expect_pop("p3_pop2", 4'd5);
    chk("p3_empty", bus.empty_o, 1);
    chk("p3_data0", bus.data_o, 0);

    // fill, overflow, set-wins-over-clear, drain, clear
    for (int i = 0; i < 8; i++) cyc(1'b1, 4'(i), 1'b0);
    chk("ovf_full", bus.full_o, 1);
    cyc(1'b1, 4'd9, 1'b0);
    chk("ovf_set", bus.ovf_o, 1);
    chk("ovf_level", bus.level_o, 8);
    cyc(1'b1, 4'd10, 1'b0, 1'b1);
    chk("ovf_setwins", bus.ovf_o, 1);
    for (int i = 0; i < 8; i++) expect_pop("ovf_drain", 4'(i));
    chk("ovf_empty", bus.empty_o, 1);
    chk("ovf_stick", bus.ovf_o, 1);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);
    chk("ovf_clr", bus.ovf_o, 0);

    // full with simultaneous push and pop
    for (int i = 0; i < 8; i++) cyc(1'b1, 4'(i), 1'b0);
    cyc(1'b1, 4'd12, 1'b1);
    chk("fpp_level", bus.level_o, 8);
    chk("fpp_head", bus.data_o, 1);
    chk("fpp_ovf", bus.ovf_o, 0);
    for (int i = 1; i < 8; i++) expect_pop("fpp_drain", 4'(i));
    expect_pop("fpp_last", 4'd12);

    // empty with simultaneous push and pop, then pop on empty
    cyc(1'b1, 4'd6, 1'b1);
    chk("epp_level", bus.level_o, 1);
    chk("epp_data", bus.data_o, 6);
    cyc(1'b0, 4'h0, 1'b1);
    cyc(1'b0, 4'h0, 1'b1);
    chk("pope_level", bus.level_o, 0);
    chk("pope_empty", bus.empty_o, 1);
    chk("pope_data", bus.data_o, 0);

    // filter behaviour
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 4'd2, 1'b0);
    cyc(1'b1, 4'd2, 1'b0);
    cyc(1'b1, 4'd2, 1'b0);
    cyc(1'b1, 4'd3, 1'b0);
    cyc(1'b1, 4'd3, 1'b0);
    cyc(1'b1, 4'd2, 1'b0);
`ifdef CCF_CHANGE_FILTER_EN
    exp_f = '{2, 3, 2};
`else
    exp_f = '{2, 2, 2, 3, 3, 2};
`endif
    chk("filt_level", bus.level_o, exp_f.size());
    foreach (exp_f[i]) expect_pop("filt_drain", 4'(exp_f[i]));
    chk("filt_empty", bus.empty_o, 1);

    // reset overrides push/pop; first sample after reset always passes
    cyc(1'b1, 4'd6, 1'b0);
    cyc(1'b1, 4'd7, 1'b0);
    cyc(1'b1, 4'd8, 1'b0);
    cyc(1'b1, 4'd9, 1'b0);
    cyc(1'b1, 4'd2, 1'b0);
    chk("r5_level", bus.level_o, 5);
    cyc(1'b1, 4'd3, 1'b1, 1'b0, 1'b1);
    chk("rr_level", bus.level_o, 0);
    chk("rr_empty", bus.empty_o, 1);
    chk("rr_ovf", bus.ovf_o, 0);
    cyc(1'b1, 4'd2, 1'b0);
    chk("rr_first_level", bus.level_o, 1);
    chk("rr_first_data", bus.data_o, 2);

    // mixed traffic, checked cycle by cycle against the model
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 4) != 0, 4'($urandom_range(0, 3)), ($urandom % 3) == 0,
          ($urandom % 16) == 0, ($urandom % 97) == 0);
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
